// File: rtl/inst_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_fetch_queue : in-order slot queue between fetch requests and decode.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [31:0]      issue_pc,
  input  logic             issue_exc,
  input  logic [4:0]       issue_exccode,
  input  logic             inst_data_ok,
  input  logic [31:0]      inst_rdata,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic             out_exc,
  output logic [4:0]       out_exccode,
  output logic [CNT_W-1:0] level,
  output logic [31:0]      perfcnt_starve
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      pc_q      [DEPTH];
  logic [31:0]      pc_d      [DEPTH];
  logic [31:0]      inst_q    [DEPTH];
  logic [31:0]      inst_d    [DEPTH];
  logic [4:0]       exccode_q [DEPTH];
  logic [4:0]       exccode_d [DEPTH];
  logic [DEPTH-1:0] exc_q, exc_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] disc_cnt_q, disc_cnt_d;
  logic [31:0]      perf_q, perf_d;

  logic             fill_hit;
  logic [PTR_W-1:0] fill_idx;
  logic [PTR_W-1:0] scan_idx;
  logic [CNT_W-1:0] owed;
  logic             issue_fire;
  logic             pop;

  assign issue_ready    = !flush && (cnt_q < CNT_W'(DEPTH)) && (disc_cnt_q == '0);
  assign out_valid      = (cnt_q != '0) && filled_q[rd_ptr_q];
  assign out_pc         = pc_q[rd_ptr_q];
  assign out_inst       = inst_q[rd_ptr_q];
  assign out_exc        = exc_q[rd_ptr_q];
  assign out_exccode    = exccode_q[rd_ptr_q];
  assign level          = cnt_q;
  assign perfcnt_starve = perf_q;
  assign issue_fire     = issue_valid && issue_ready;
  assign pop            = out_valid && out_ready && !flush;

  // Walk allocated slots youngest-to-oldest so the oldest awaiting slot wins the fill.
  always_comb begin
    fill_hit = 1'b0;
    fill_idx = '0;
    scan_idx = '0;
    owed     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      scan_idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < cnt_q) && mem_q[scan_idx] && !filled_q[scan_idx]) begin
        fill_hit = 1'b1;
        fill_idx = scan_idx;
        owed     = owed + CNT_W'(1);
      end
    end
  end

  always_comb begin
    pc_d       = pc_q;
    inst_d     = inst_q;
    exccode_d  = exccode_q;
    exc_d      = exc_q;
    mem_d      = mem_q;
    filled_d   = filled_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    disc_cnt_d = disc_cnt_q;
    perf_d     = perf_q;

    if (out_ready && !out_valid && !flush) begin
      perf_d = perf_q + 32'd1;
    end

    if (flush) begin
      filled_d = '0;
      cnt_d    = '0;
      rd_ptr_d = wr_ptr_q;
      // A repeat flush has nothing new allocated, so the pending discard count stands.
      if (disc_cnt_q == '0) begin
        disc_cnt_d = owed;
      end
    end else begin
      if (inst_data_ok) begin
        if (disc_cnt_q != '0) begin
          disc_cnt_d = disc_cnt_q - CNT_W'(1);
        end else if (fill_hit) begin
          inst_d[fill_idx]   = inst_rdata;
          filled_d[fill_idx] = 1'b1;
        end
      end
      if (pop) begin
        filled_d[rd_ptr_q] = 1'b0;
        rd_ptr_d           = rd_ptr_q + PTR_W'(1);
      end
      if (issue_fire) begin
        pc_d[wr_ptr_q]      = issue_pc;
        inst_d[wr_ptr_q]    = 32'h0;
        exc_d[wr_ptr_q]     = issue_exc;
        exccode_d[wr_ptr_q] = issue_exccode;
        mem_d[wr_ptr_q]     = !issue_exc;
        filled_d[wr_ptr_q]  = issue_exc;
        wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end
      case ({issue_fire, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]      <= '0;
        inst_q[i]    <= '0;
        exccode_q[i] <= '0;
      end
      exc_q      <= '0;
      mem_q      <= '0;
      filled_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      disc_cnt_q <= '0;
      perf_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      exccode_q  <= exccode_d;
      exc_q      <= exc_d;
      mem_q      <= mem_d;
      filled_q   <= filled_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      disc_cnt_q <= disc_cnt_d;
      perf_q     <= perf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// Randomized bench for inst_fetch_queue: a queue-based reference model acts as the
// scoreboard; the monitor compares every popped slot and the status outputs.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int NCYC  = 3000;

  logic             clk = 1'b0;
  logic             resetn;
  logic             issue_valid;
  logic             issue_ready;
  logic [31:0]      issue_pc;
  logic             issue_exc;
  logic [4:0]       issue_exccode;
  logic             inst_data_ok;
  logic [31:0]      inst_rdata;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_inst;
  logic             out_exc;
  logic [4:0]       out_exccode;
  logic [CNT_W-1:0] level;
  logic [31:0]      perfcnt_starve;

  inst_fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_pc      (issue_pc),
    .issue_exc     (issue_exc),
    .issue_exccode (issue_exccode),
    .inst_data_ok  (inst_data_ok),
    .inst_rdata    (inst_rdata),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .out_exc       (out_exc),
    .out_exccode   (out_exccode),
    .level         (level),
    .perfcnt_starve(perfcnt_starve)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [4:0]  code;
    logic        mem;
    logic        filled;
  } slot_t;

  slot_t       sb[$];
  int          disc      = 0;
  logic [31:0] perf      = 32'h0;
  bit          mon_en    = 1'b0;
  bit          reset_chk = 1'b1;
  int          checks    = 0;
  int          errors    = 0;
  int          pops      = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Monitor + reference model: compare this cycle's outputs, then advance the model
  // with the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    bit    exp_ready;
    bit    exp_valid;
    bit    do_pop;
    bit    done;
    int    n_owed;
    slot_t s;
    if (mon_en) begin
      exp_ready = !flush && (sb.size() < DEPTH) && (disc == 0);
      exp_valid = (sb.size() != 0) && sb[0].filled;
      check("issue_ready", {31'h0, issue_ready}, {31'h0, exp_ready});
      check("out_valid", {31'h0, out_valid}, {31'h0, exp_valid});
      check("level", {29'h0, level}, sb.size());
      check("perfcnt_starve", perfcnt_starve, perf);
      if (reset_chk) begin
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_out_exc", {31'h0, out_exc}, 32'h0);
        check("rst_out_exccode", {27'h0, out_exccode}, 32'h0);
        reset_chk = 1'b0;
      end
      do_pop = exp_valid && out_ready && !flush;
      if (do_pop) begin
        pops++;
        check("pop_pc", out_pc, sb[0].pc);
        check("pop_inst", out_inst, sb[0].inst);
        check("pop_exc", {31'h0, out_exc}, {31'h0, sb[0].exc});
        check("pop_exccode", {27'h0, out_exccode}, {27'h0, sb[0].code});
      end

      if (!resetn) begin
        sb.delete();
        disc      = 0;
        perf      = 32'h0;
        reset_chk = 1'b1;
      end else if (flush) begin
        if (disc == 0) begin
          n_owed = 0;
          foreach (sb[i]) if (sb[i].mem && !sb[i].filled) n_owed++;
          disc = n_owed;
        end
        sb.delete();
      end else begin
        if (out_ready && !exp_valid) perf = perf + 32'h1;
        if (inst_data_ok) begin
          if (disc > 0) begin
            disc--;
          end else begin
            done = 1'b0;
            for (int i = 0; i < sb.size(); i++) begin
              if (!done && sb[i].mem && !sb[i].filled) begin
                sb[i].inst   = inst_rdata;
                sb[i].filled = 1'b1;
                done         = 1'b1;
              end
            end
          end
        end
        if (do_pop) void'(sb.pop_front());
        if (issue_valid && exp_ready) begin
          s.pc     = issue_pc;
          s.inst   = 32'h0;
          s.exc    = issue_exc;
          s.code   = issue_exccode;
          s.mem    = !issue_exc;
          s.filled = issue_exc;
          sb.push_back(s);
        end
      end
    end
  end

  // Driver: per-phase probabilities steer the queue through full, flush-heavy,
  // drain-heavy and streaming regimes.
  initial begin
    int p_iss, p_dok, p_rdy, p_fl;
    resetn        = 1'b0;
    issue_valid   = 1'b0;
    issue_pc      = 32'h0;
    issue_exc     = 1'b0;
    issue_exccode = 5'h0;
    inst_data_ok  = 1'b0;
    inst_rdata    = 32'h0;
    flush         = 1'b0;
    out_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk);
    #1 resetn = 1'b1;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      case (c / 500)
        0:       begin p_iss = 60; p_dok = 50; p_rdy = 70; p_fl = 3;  end
        1:       begin p_iss = 80; p_dok = 40; p_rdy = 10; p_fl = 2;  end
        2:       begin p_iss = 60; p_dok = 50; p_rdy = 60; p_fl = 15; end
        3:       begin p_iss = 50; p_dok = 70; p_rdy = 90; p_fl = 2;  end
        4:       begin p_iss = 70; p_dok = 30; p_rdy = 40; p_fl = 8;  end
        default: begin p_iss = 90; p_dok = 90; p_rdy = 90; p_fl = 0;  end
      endcase
      issue_valid   = ($urandom_range(99) < p_iss);
      issue_pc      = $urandom & 32'hFFFF_FFFC;
      issue_exc     = ($urandom_range(99) < 20);
      issue_exccode = 5'($urandom);
      inst_data_ok  = ($urandom_range(99) < p_dok);
      inst_rdata    = $urandom;
      out_ready     = ($urandom_range(99) < p_rdy);
      flush         = ($urandom_range(99) < p_fl);
      resetn        = !(c == 1730 || c == 2620);
    end
    @(posedge clk);
    #1;
    issue_valid  = 1'b0;
    inst_data_ok = 1'b0;
    flush        = 1'b0;
    out_ready    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (pops < 50) begin
      errors++;
      $display("FAIL pop_activity got=%0d exp>=50", pops);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
